// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: command codes, FSM states and
// status flag bit positions.
package alu_pkg;

  localparam int CMD_BITS = 4;

  localparam logic [CMD_BITS-1:0] CMD_MOV = 4'b0001;
  localparam logic [CMD_BITS-1:0] CMD_ADD = 4'b0010;
  localparam logic [CMD_BITS-1:0] CMD_ADC = 4'b0011;
  localparam logic [CMD_BITS-1:0] CMD_SUB = 4'b0100;
  localparam logic [CMD_BITS-1:0] CMD_SBC = 4'b0101;
  localparam logic [CMD_BITS-1:0] CMD_AND = 4'b0110;
  localparam logic [CMD_BITS-1:0] CMD_ORR = 4'b0111;
  localparam logic [CMD_BITS-1:0] CMD_EOR = 4'b1000;
  localparam logic [CMD_BITS-1:0] CMD_MVN = 4'b1001;
  localparam logic [CMD_BITS-1:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// done_o/prod_o are combinational so the caller can register the final step.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] acc_next_s;

  // Step datapath and next-state selection.
  always_comb begin
    acc_next_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
    done_o     = run_q & (cnt_q == LAST_STEP);
    prod_o     = acc_next_s;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    if (start_i) begin
      acc_d    = {WIDTH{1'b0}};
      mcand_d  = a_i;
      mplier_d = b_i;
      cnt_d    = {CNT_W{1'b0}};
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_next_s;
      mcand_d  = mcand_q << 1'b1;
      mplier_d = mplier_q >> 1'b1;
      cnt_d    = cnt_q + CNT_W'(1);
      run_d    = ~done_o;
    end else begin
      run_d    = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked execute-stage ALU: single-cycle ARM data-processing ops plus an
// iterative MUL, with registered result and NZCV flags.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] exe_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             carry_in,
  input  logic             set_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       status_out,
  output logic             busy
);

  localparam int M = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       status_q, status_d;
  logic             out_valid_q, out_valid_d;
  logic             set_q, set_d;

  logic             accept_s, retire_s, is_mul_s, mul_start_s, mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;
  logic [WIDTH:0]   ext_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s, v_s;
  logic [3:0]       flags_s;
  logic [3:0]       mul_flags_s;

  assign in_ready   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept_s   = in_valid & in_ready;
  assign retire_s   = (state_q == ST_DONE) & out_ready;
  assign is_mul_s   = (exe_cmd == CMD_W'(CMD_MUL));
  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign status_out = status_q;
  assign busy       = (state_q == ST_MUL_BUSY);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start_i(mul_start_s),
    .a_i    (val1),
    .b_i    (val2),
    .done_o (mul_done_s),
    .prod_o (mul_prod_s)
  );

  // Single-cycle datapath; arithmetic is done one bit wider to expose carry/borrow.
  always_comb begin
    ext_s = {(WIDTH+1){1'b0}};
    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (exe_cmd)
      CMD_W'(CMD_MOV): res_s = val2;
      CMD_W'(CMD_MVN): res_s = ~val2;
      CMD_W'(CMD_ADD), CMD_W'(CMD_ADC): begin
        ext_s = {1'b0, val1} + {1'b0, val2}
              + {{WIDTH{1'b0}}, (exe_cmd == CMD_W'(CMD_ADC)) & carry_in};
        res_s = ext_s[M:0];
        c_s   = ext_s[WIDTH];
        v_s   = (val1[M] == val2[M]) & (res_s[M] != val1[M]);
      end
      CMD_W'(CMD_SUB), CMD_W'(CMD_SBC): begin
        ext_s = {1'b0, val1} - {1'b0, val2}
              - {{WIDTH{1'b0}}, (exe_cmd == CMD_W'(CMD_SBC)) & carry_in};
        res_s = ext_s[M:0];
        c_s   = ext_s[WIDTH];
        v_s   = (val1[M] != val2[M]) & (res_s[M] != val1[M]);
      end
      CMD_W'(CMD_AND): res_s = val1 & val2;
      CMD_W'(CMD_ORR): res_s = val1 | val2;
      CMD_W'(CMD_EOR): res_s = val1 ^ val2;
      default:         res_s = {WIDTH{1'b0}};
    endcase
    flags_s         = 4'b0000;
    flags_s[FLAG_N] = res_s[M];
    flags_s[FLAG_Z] = (res_s == {WIDTH{1'b0}});
    flags_s[FLAG_C] = c_s;
    flags_s[FLAG_V] = v_s;
    // MUL leaves C and V untouched.
    mul_flags_s         = status_q;
    mul_flags_s[FLAG_N] = mul_prod_s[M];
    mul_flags_s[FLAG_Z] = (mul_prod_s == {WIDTH{1'b0}});
  end

  // Control FSM next-state, result/flag load and set_status capture.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    status_d    = status_q;
    out_valid_d = out_valid_q;
    set_d       = set_q;
    mul_start_s = 1'b0;
    if ((state_q == ST_MUL_BUSY) && mul_done_s) begin
      state_d     = ST_DONE;
      result_d    = mul_prod_s;
      out_valid_d = 1'b1;
      if (set_q) begin
        status_d = mul_flags_s;
      end else begin
        status_d = status_q;
      end
    end else if (accept_s) begin
      set_d = set_status;
      if (is_mul_s) begin
        state_d     = ST_MUL_BUSY;
        out_valid_d = 1'b0;
        mul_start_s = 1'b1;
      end else begin
        state_d     = ST_DONE;
        result_d    = res_s;
        out_valid_d = 1'b1;
        if (set_status) begin
          status_d = flags_s;
        end else begin
          status_d = status_q;
        end
      end
    end else if (retire_s) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // Registered state, result, flags and handshake output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= {WIDTH{1'b0}};
      status_q    <= 4'b0000;
      out_valid_q <= 1'b0;
      set_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
      set_q       <= set_d;
    end
  end

endmodule
